// File: rtl/latch_bank_seq.sv
// latch_bank_seq: command sequencer for a bank of transparent-high latches
// with an active-low clear (RN) and an active-low preset (SETN).
// Each accepted WRITE, CLEAR or PRESET is expanded into correctly timed
// edges on the shared E / D / RN / SETN nets. Setup, pulse, hold and
// recovery windows are given as clock-cycle counts.
// Optional feature: define LATCH_BANK_SEQ_READBACK_EN to add the lat_q
// readback input and the sticky mismatch flag.
module latch_bank_seq #(
  parameter int WIDTH     = 8,
  parameter int SETUP_CYC = 1,
  parameter int PULSE_CYC = 2,
  parameter int HOLD_CYC  = 1,
  parameter int RECOV_CYC = 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             req_valid,
  output logic             req_ready,
  input  logic [1:0]       req_op,
  input  logic [WIDTH-1:0] req_data,
  output logic             busy,
  output logic             done,
  output logic             lat_e,
  output logic [WIDTH-1:0] lat_d,
  output logic             lat_rn,
  output logic             lat_setn
`ifdef LATCH_BANK_SEQ_READBACK_EN
  ,
  input  logic [WIDTH-1:0] lat_q,
  output logic             mismatch
`endif
);

  // The timing counts are limited to what the 4-bit counter can hold.
  if (SETUP_CYC < 1 || SETUP_CYC > 15) begin : g_bad_setup
    $error("SETUP_CYC out of range 1..15");
  end
  if (PULSE_CYC < 1 || PULSE_CYC > 15) begin : g_bad_pulse
    $error("PULSE_CYC out of range 1..15");
  end
  if (HOLD_CYC < 1 || HOLD_CYC > 15) begin : g_bad_hold
    $error("HOLD_CYC out of range 1..15");
  end
  if (RECOV_CYC < 1 || RECOV_CYC > 15) begin : g_bad_recov
    $error("RECOV_CYC out of range 1..15");
  end

  typedef enum logic [1:0] {OP_WRITE, OP_CLEAR, OP_PRESET, OP_NOP} op_e;

  // CMD is the single cycle between acceptance and the first net action;
  // it keeps req_ready low so a second command cannot slip in.
  typedef enum logic [2:0] {
    IDLE, CMD, SETUP, EPULSE, HOLD, RPULSE, SPULSE, RECOV
  } state_e;

  // Counter reload values: a window of N cycles counts N-1 down to 0.
  localparam logic [3:0] SETUP_LD = 4'(SETUP_CYC - 1);
  localparam logic [3:0] PULSE_LD = 4'(PULSE_CYC - 1);
  localparam logic [3:0] HOLD_LD  = 4'(HOLD_CYC - 1);
  localparam logic [3:0] RECOV_LD = 4'(RECOV_CYC - 1);

  state_e           state;
  logic [3:0]       cnt;
  op_e              op_q;
  logic [WIDTH-1:0] data_q;

  assign req_ready = (state == IDLE) && !rst;

  // Command sequencer: one state per timing window, all nets registered.
  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= IDLE;
      cnt      <= '0;
      op_q     <= OP_NOP;
      data_q   <= '0;
      lat_e    <= 1'b0;
      lat_d    <= '0;
      lat_rn   <= 1'b1;
      lat_setn <= 1'b1;
      done     <= 1'b0;
      busy     <= 1'b0;
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: begin
          if (req_valid) begin
            op_q   <= op_e'(req_op);
            data_q <= req_data;
            state  <= CMD;
          end
        end
        CMD: begin
          case (op_q)
            OP_WRITE: begin
              lat_d <= data_q;
              cnt   <= SETUP_LD;
              busy  <= 1'b1;
              state <= SETUP;
            end
            OP_CLEAR: begin
              lat_rn <= 1'b0;
              cnt    <= PULSE_LD;
              busy   <= 1'b1;
              state  <= RPULSE;
            end
            OP_PRESET: begin
              lat_setn <= 1'b0;
              cnt      <= PULSE_LD;
              busy     <= 1'b1;
              state    <= SPULSE;
            end
            default: begin
              done  <= 1'b1;
              state <= IDLE;
            end
          endcase
        end
        SETUP: begin
          if (cnt == 4'd0) begin
            lat_e <= 1'b1;
            cnt   <= PULSE_LD;
            state <= EPULSE;
          end else cnt <= cnt - 4'd1;
        end
        EPULSE: begin
          if (cnt == 4'd0) begin
            lat_e <= 1'b0;
            cnt   <= HOLD_LD;
            state <= HOLD;
          end else cnt <= cnt - 4'd1;
        end
        RPULSE, SPULSE: begin
          if (cnt == 4'd0) begin
            lat_rn   <= 1'b1;
            lat_setn <= 1'b1;
            cnt      <= RECOV_LD;
            state    <= RECOV;
          end else cnt <= cnt - 4'd1;
        end
        HOLD, RECOV: begin
          if (cnt == 4'd0) begin
            done  <= 1'b1;
            busy  <= 1'b0;
            state <= IDLE;
          end else cnt <= cnt - 4'd1;
        end
        default: state <= IDLE;
      endcase
    end
  end

`ifdef LATCH_BANK_SEQ_READBACK_EN
  logic             fin;
  logic [WIDTH-1:0] exp_q;
  logic [WIDTH-1:0] exp_nxt;

  // fin marks the edge at which done will assert.
  assign fin = ((state == CMD) && (op_q == OP_NOP)) ||
               (((state == HOLD) || (state == RECOV)) && (cnt == 4'd0));

  always_comb begin
    exp_nxt = exp_q;
    case (op_q)
      OP_WRITE:  exp_nxt = data_q;
      OP_CLEAR:  exp_nxt = '0;
      OP_PRESET: exp_nxt = '1;
      default:   exp_nxt = exp_q;
    endcase
  end

  // Shadow of the expected bank contents; compared one edge after done.
  always_ff @(posedge clk) begin
    if (rst) begin
      exp_q    <= '0;
      mismatch <= 1'b0;
    end else begin
      if (fin) exp_q <= exp_nxt;
      if (done && (lat_q != exp_q)) mismatch <= 1'b1;
    end
  end
`else
  // No readback path in this build.
`endif

endmodule

// File: tb/tb_latch_bank_seq.sv
// Bench for latch_bank_seq: reset checks, a directed command table,
// mid-operation reset, randomized commands against a timing model derived
// from the window lengths, and bank-net invariants checked every cycle.
module tb_latch_bank_seq;
  localparam int W = 8;
  localparam int S = 1;
  localparam int P = 2;
  localparam int H = 1;
  localparam int R = 1;

  logic         clk = 1'b0;
  logic         rst;
  logic         req_valid;
  logic         req_ready;
  logic [1:0]   req_op;
  logic [W-1:0] req_data;
  logic         busy, done, lat_e, lat_rn, lat_setn;
  logic [W-1:0] lat_d;

  int checks = 0;
  int errors = 0;
  logic [W-1:0] md = '0;   // model of the bank data bus

`ifdef LATCH_BANK_SEQ_READBACK_EN
  logic [W-1:0] lat_q, qm = '0;
  logic         mismatch;
  bit           stuck = 1'b0;
  assign lat_q = stuck ? (qm & 8'hFE) : qm;
  // Behavioural latch bank fed from the sequencer nets.
  always @(posedge clk) begin
    if (rst) qm <= '0;
    else if (!lat_rn) qm <= '0;
    else if (!lat_setn) qm <= '1;
    else if (lat_e) qm <= lat_d;
  end
`endif

  latch_bank_seq #(.WIDTH(W), .SETUP_CYC(S), .PULSE_CYC(P),
                   .HOLD_CYC(H), .RECOV_CYC(R)) dut (
    .clk(clk), .rst(rst), .req_valid(req_valid), .req_ready(req_ready),
    .req_op(req_op), .req_data(req_data), .busy(busy), .done(done),
    .lat_e(lat_e), .lat_d(lat_d), .lat_rn(lat_rn), .lat_setn(lat_setn)
`ifdef LATCH_BANK_SEQ_READBACK_EN
    , .lat_q(lat_q), .mismatch(mismatch)
`endif
  );

  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s got %0h expected %0h", nm, act, exp);
    end
  endtask

  // Bank-net invariants, sampled away from the active edge.
  logic         prst = 1'b1, pe = 1'b0;
  logic [W-1:0] pd = '0;
  int           hc = 0;
  always @(negedge clk) begin
    if (!rst && !prst) begin
      checks++;
      assert (lat_rn || lat_setn) else begin
        errors++; $display("FAIL inv_rn_setn both low");
      end
      checks++;
      assert (!lat_e || (lat_rn && lat_setn)) else begin
        errors++; $display("FAIL inv_e_during_reset e=%0b rn=%0b setn=%0b", lat_e, lat_rn, lat_setn);
      end
      checks++;
      assert (!((lat_d !== pd) && (lat_e || pe || hc > 0))) else begin
        errors++; $display("FAIL inv_d_stable got %0h expected %0h", lat_d, pd);
      end
    end
    prst <= rst;
    pe   <= lat_e;
    pd   <= lat_d;
    if (rst) hc <= 0;
    else if (pe && !lat_e) hc <= H - 1;
    else if (hc > 0) hc <= hc - 1;
  end

  // Issue one command and check every cycle until done against the window
  // arithmetic. Leaves req_valid high; caller drops it or issues again.
  task automatic run(input logic [1:0] op, input logic [W-1:0] data,
                     output int waited, output int dt);
    int L;
    req_valid = 1'b1; req_op = op; req_data = data;
    waited = 0; dt = -1;
    while (!req_ready && waited < 20) begin @(negedge clk); waited++; end
    chk("accept_ready", req_ready, 1);
    if (!req_ready) begin req_valid = 1'b0; return; end
    case (op)
      2'd0:       L = 1 + S + P + H;
      2'd1, 2'd2: L = 1 + P + R;
      default:    L = 1;
    endcase
    for (int t = 0; t <= L; t++) begin
      @(negedge clk);
      if (t == 1 && op == 2'd0) md = data;
      if (done && dt < 0) dt = t;
      chk("lat_e",    lat_e,    (op == 2'd0 && t >= 1 + S && t < 1 + S + P));
      chk("lat_rn",   lat_rn,   !(op == 2'd1 && t >= 1 && t < 1 + P));
      chk("lat_setn", lat_setn, !(op == 2'd2 && t >= 1 && t < 1 + P));
      chk("busy",     busy,     (t >= 1 && t < L));
      chk("done",     done,     (t == L));
      chk("ready",    req_ready,(t == L));
      chk("lat_d",    lat_d,    md);
    end
  endtask

  task automatic gap(input int n);
    req_valid = 1'b0; req_op = 2'd3;
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      chk("idle_done", done, 0);
      chk("idle_busy", busy, 0);
      chk("idle_ready", req_ready, 1);
      chk("idle_lat_d", lat_d, md);
    end
  endtask

  typedef struct {
    logic [1:0]   op;
    logic [W-1:0] data;
    int           len;
    logic [W-1:0] d_after;
    bit           b2b;   // issued in the previous command's done cycle
  } vec_t;

  vec_t tbl[7];

  initial begin
    int wt, dt;
    tbl[0] = '{2'd0, 8'hA5, 5, 8'hA5, 1'b0};
    tbl[1] = '{2'd1, 8'h00, 4, 8'hA5, 1'b0};
    tbl[2] = '{2'd2, 8'hFF, 4, 8'hA5, 1'b0};
    tbl[3] = '{2'd3, 8'h77, 1, 8'hA5, 1'b0};
    tbl[4] = '{2'd0, 8'h3C, 5, 8'h3C, 1'b0};
    tbl[5] = '{2'd2, 8'h00, 4, 8'h3C, 1'b1};
    tbl[6] = '{2'd0, 8'h81, 5, 8'h81, 1'b1};

    rst = 1'b1; req_valid = 1'b0; req_op = 2'd3; req_data = '0;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk("rst_e", lat_e, 0);     chk("rst_d", lat_d, 0);
      chk("rst_rn", lat_rn, 1);   chk("rst_setn", lat_setn, 1);
      chk("rst_done", done, 0);   chk("rst_busy", busy, 0);
      chk("rst_ready", req_ready, 0);
    end
    rst = 1'b0;
    #1 chk("ready_after_rst", req_ready, 1);
    @(negedge clk);

    // Directed table; b2b entries must be accepted in the done cycle.
    for (int i = 0; i < 7; i++) begin
      run(tbl[i].op, tbl[i].data, wt, dt);
      chk("tbl_len", dt, tbl[i].len);
      chk("tbl_d_after", lat_d, tbl[i].d_after);
      if (tbl[i].b2b) chk("tbl_b2b_wait", wt, 0);
      if (i == 6 || !tbl[i+1].b2b) gap(2);
    end

    // Reset during EPULSE of a WRITE.
    req_valid = 1'b1; req_op = 2'd0; req_data = 8'h5A;
    @(negedge clk); req_valid = 1'b0;   // t=0
    @(negedge clk);                      // t=1 SETUP
    @(negedge clk);                      // t=2 EPULSE
    chk("mid_e_high", lat_e, 1);
    rst = 1'b1;
    @(negedge clk);
    md = '0;
    chk("mid_e", lat_e, 0);     chk("mid_rn", lat_rn, 1);
    chk("mid_setn", lat_setn, 1); chk("mid_done", done, 0);
    chk("mid_busy", busy, 0);   chk("mid_ready", req_ready, 0);
    rst = 1'b0;
    @(negedge clk);
    chk("mid_no_done", done, 0);
    run(2'd3, 8'h00, wt, dt);
    chk("mid_nop_len", dt, 1);
    gap(1);

    // Randomized commands, sometimes back to back.
    for (int i = 0; i < 40; i++) begin
      logic [1:0] rop;
      logic [W-1:0] rd;
      rop = 2'($urandom_range(0, 3));
      rd  = W'($urandom);
      run(rop, rd, wt, dt);
      chk("rnd_len", dt, (rop == 2'd0) ? 1+S+P+H : (rop == 2'd3) ? 1 : 1+P+R);
      if ($urandom_range(0, 1) == 0) gap($urandom_range(1, 3));
    end
    gap(2);

`ifdef LATCH_BANK_SEQ_READBACK_EN
    chk("rb_clean", mismatch, 0);
    stuck = 1'b1;
    run(2'd0, 8'hFF, wt, dt);
    gap(1);
    chk("rb_mismatch_set", mismatch, 1);
    stuck = 1'b0;
    run(2'd1, 8'h00, wt, dt);
    gap(2);
    chk("rb_mismatch_sticky", mismatch, 1);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    md = '0;
    chk("rb_mismatch_rst", mismatch, 0);
    gap(1);
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog timeout");
    $fatal(1, "timeout");
  end
endmodule
